rps_match_referee: RTL and testbench

//  Sequential best-of-N Rock-Paper-Scissors referee. Accepts one round (player/computer choice)
//  per valid/ready handshake, classifies it, keeps running scores, and declares match winner or

---
 rtl/rps_pkg.sv | 6 +
 rtl/rps_outcome.sv | 21 ++
 rtl/rps_match_referee.sv | 98 +++++++++
 tb/tb_rps_match_referee.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors referee: choices, round results, FSM states.
package rps_pkg;
  typedef enum logic [1:0] {NONE = 2'b00, ROCK = 2'b01, PAPER = 2'b10, SCISSORS = 2'b11} choice_t;
  typedef enum logic [1:0] {TIE = 2'b00, P_WIN = 2'b01, C_WIN = 2'b10, INVALID = 2'b11} result_t;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/rps_outcome.sv
// Combinational round classifier: two 2-bit choices -> 2-bit result code.
module rps_outcome
  import rps_pkg::*;
(
  input  logic [1:0] player_choice,
  input  logic [1:0] computer_choice,
  output logic [1:0] result_code
);
  logic p_beats_c;

  assign p_beats_c = (player_choice == ROCK     && computer_choice == SCISSORS) ||
                     (player_choice == PAPER    && computer_choice == ROCK)     ||
                     (player_choice == SCISSORS && computer_choice == PAPER);

  always_comb begin
    result_code = C_WIN;
    if (player_choice == NONE || computer_choice == NONE) result_code = INVALID;
    else if (player_choice == computer_choice)            result_code = TIE;
    else if (p_beats_c)                                   result_code = P_WIN;
  end
endmodule

// File: rtl/rps_match_referee.sv
// Best-of-N rock-paper-scissors referee: valid/ready round intake, running scores,
// match winner / draw declaration.
module rps_match_referee
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 7,
  localparam int CNT_W        = $clog2(MAX_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             round_valid,
  output logic             round_ready,
  input  logic [1:0]       player_choice,
  input  logic [1:0]       computer_choice,
  output logic             result_valid,
  output logic [1:0]       result_code,
  output logic [CNT_W-1:0] player_score,
  output logic [CNT_W-1:0] computer_score,
  output logic [CNT_W-1:0] round_count,
  output logic             match_done,
  output logic             player_wins,
  output logic             match_draw
);
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > MAX_ROUNDS) begin : g_bad_rtw
    $error("rps_match_referee: ROUNDS_TO_WIN must be in 1..MAX_ROUNDS");
  end
  if (MAX_ROUNDS < 1) begin : g_bad_max
    $error("rps_match_referee: MAX_ROUNDS must be >= 1");
  end

  state_t           state;
  logic [1:0]       code;
  logic             accept, scored, p_pt, c_pt;
  logic [CNT_W-1:0] ps_nxt, cs_nxt, rc_nxt;
  logic             win_p, win_c, end_now;

  rps_outcome u_outcome (
    .player_choice   (player_choice),
    .computer_choice (computer_choice),
    .result_code     (code)
  );

  assign round_ready = (state == PLAY) && !start;
  assign accept      = round_valid && round_ready;

  // Invalid rounds are reported but never touch counters or the FSM.
  always_comb begin
    scored  = accept && (code != INVALID);
    p_pt    = accept && (code == P_WIN);
    c_pt    = accept && (code == C_WIN);
    ps_nxt  = player_score   + CNT_W'(p_pt);
    cs_nxt  = computer_score + CNT_W'(c_pt);
    rc_nxt  = round_count    + CNT_W'(scored);
    win_p   = ps_nxt == CNT_W'(ROUNDS_TO_WIN);
    win_c   = cs_nxt == CNT_W'(ROUNDS_TO_WIN);
    end_now = scored && (win_p || win_c || rc_nxt == CNT_W'(MAX_ROUNDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      result_valid   <= 1'b0;
      result_code    <= TIE;
      player_score   <= '0;
      computer_score <= '0;
      round_count    <= '0;
      match_done     <= 1'b0;
      player_wins    <= 1'b0;
      match_draw     <= 1'b0;
    end else begin
      result_valid <= accept;
      if (start) begin
        state          <= PLAY;
        result_code    <= TIE;
        player_score   <= '0;
        computer_score <= '0;
        round_count    <= '0;
        match_done     <= 1'b0;
        player_wins    <= 1'b0;
        match_draw     <= 1'b0;
      end else if (accept) begin
        result_code    <= code;
        player_score   <= ps_nxt;
        computer_score <= cs_nxt;
        round_count    <= rc_nxt;
        if (end_now) begin
          // A winner on the final allowed round takes precedence over a draw.
          state       <= DONE;
          match_done  <= 1'b1;
          player_wins <= win_p;
          match_draw  <= !win_p && !win_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_rps_match_referee.sv
// Self-checking bench: directed scenarios plus random rounds against a rules-level model.
module tb_rps_match_referee;
  localparam int RTW = 2, MR = 7, CW = 3;
  localparam int CWB = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, round_valid = 1'b0;
  logic [1:0] pc = 2'b00, cc = 2'b00;
  logic round_ready, result_valid, match_done, player_wins, match_draw;
  logic [1:0] result_code;
  logic [CW-1:0] player_score, computer_score, round_count;

  logic start_b = 1'b0, round_valid_b = 1'b0;
  logic [1:0] pc_b = 2'b00, cc_b = 2'b00;
  logic round_ready_b, result_valid_b, match_done_b, player_wins_b, match_draw_b;
  logic [1:0] result_code_b;
  logic [CWB-1:0] player_score_b, computer_score_b, round_count_b;

  int n_tests = 0, n_fail = 0;
  int m_phase = 0, m_ps = 0, m_cs = 0, m_rc = 0, m_code = 0;
  int m_rv = 0, m_done = 0, m_pw = 0, m_draw = 0;

  always #5 clk = ~clk;

  rps_match_referee #(.ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .round_valid(round_valid),
    .round_ready(round_ready), .player_choice(pc), .computer_choice(cc),
    .result_valid(result_valid), .result_code(result_code),
    .player_score(player_score), .computer_score(computer_score),
    .round_count(round_count), .match_done(match_done),
    .player_wins(player_wins), .match_draw(match_draw));

  rps_match_referee #(.ROUNDS_TO_WIN(3), .MAX_ROUNDS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .round_valid(round_valid_b),
    .round_ready(round_ready_b), .player_choice(pc_b), .computer_choice(cc_b),
    .result_valid(result_valid_b), .result_code(result_code_b),
    .player_score(player_score_b), .computer_score(computer_score_b),
    .round_count(round_count_b), .match_done(match_done_b),
    .player_wins(player_wins_b), .match_draw(match_draw_b));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("result_valid",   32'(result_valid),   m_rv);
    chk("result_code",    32'(result_code),    m_code);
    chk("player_score",   32'(player_score),   m_ps);
    chk("computer_score", 32'(computer_score), m_cs);
    chk("round_count",    32'(round_count),    m_rc);
    chk("match_done",     32'(match_done),     m_done);
    chk("player_wins",    32'(player_wins),    m_pw);
    chk("match_draw",     32'(match_draw),     m_draw);
  endtask

  task automatic model_clear();
    m_ps = 0; m_cs = 0; m_rc = 0; m_code = 0; m_rv = 0;
    m_done = 0; m_pw = 0; m_draw = 0;
  endtask

  // Rules model: choices 1..3 in a cycle, (p - c) mod 3 == 1 means the player's choice beats.
  task automatic model_edge(input bit s, input bit v, input int p, input int c);
    int d;
    m_rv = 0;
    if (s) begin
      model_clear();
      m_phase = 1;
    end else if (v && m_phase == 1) begin
      m_rv = 1;
      if (p == 0 || c == 0) m_code = 3;
      else begin
        d = (p - c + 3) % 3;
        m_rc++;
        if (d == 0) m_code = 0;
        else if (d == 1) begin m_code = 1; m_ps++; end
        else begin m_code = 2; m_cs++; end
        if (m_ps == RTW || m_cs == RTW || m_rc == MR) begin
          m_phase = 2; m_done = 1;
          m_pw   = (m_ps == RTW) ? 1 : 0;
          m_draw = (m_ps != RTW && m_cs != RTW) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [1:0] p, input logic [1:0] c);
    start = s; round_valid = v; pc = p; cc = c;
    #1;
    chk("round_ready", 32'(round_ready), (m_phase == 1 && !s) ? 1 : 0);
    @(posedge clk); #1;
    model_edge(s, v, int'(p), int'(c));
    start = 1'b0; round_valid = 1'b0;
    check_all();
  endtask

  task automatic stepb(input bit s, input bit v, input logic [1:0] p, input logic [1:0] c);
    start_b = s; round_valid_b = v; pc_b = p; cc_b = c;
    @(posedge clk); #1;
    start_b = 1'b0; round_valid_b = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_ready", 32'(round_ready), 0);
    rst_n = 1'b1;

    // IDLE ignores rounds.
    step(0, 1, 2'b01, 2'b11);

    // Best of 3: player takes two straight rounds.
    step(1, 0, 2'b00, 2'b00);
    step(0, 1, 2'b01, 2'b11);
    chk("rock_beats_scissors", 32'(result_code), 1);
    step(0, 1, 2'b10, 2'b01);
    chk("p_match_score", 32'(player_score), 2);
    chk("p_match_done", 32'(match_done), 1);
    chk("p_match_wins", 32'(player_wins), 1);
    chk("done_ready", 32'(round_ready), 0);
    step(0, 1, 2'b11, 2'b10);

    // Seven ties force a draw.
    step(1, 0, 2'b00, 2'b00);
    repeat (7) step(0, 1, 2'b01, 2'b01);
    chk("draw_rounds", 32'(round_count), 7);
    chk("draw_flag", 32'(match_draw), 1);

    // Invalid choice: reported, counters untouched.
    step(1, 0, 2'b00, 2'b00);
    step(0, 1, 2'b00, 2'b10);
    chk("invalid_pulse", 32'(result_valid), 1);
    chk("invalid_code", 32'(result_code), 3);
    chk("invalid_count", 32'(round_count), 0);

    // start beats a simultaneous round at 1-0.
    step(1, 0, 2'b00, 2'b00);
    step(0, 1, 2'b10, 2'b01);
    step(1, 1, 2'b10, 2'b01);
    chk("abort_no_result", 32'(result_valid), 0);
    chk("abort_score", 32'(player_score), 0);
    step(0, 0, 2'b00, 2'b00);

    // Asynchronous reset at 1-1, away from any clock edge.
    step(1, 0, 2'b00, 2'b00);
    step(0, 1, 2'b01, 2'b11);
    step(0, 1, 2'b01, 2'b10);
    round_valid = 1'b1; pc = 2'b11; cc = 2'b10;
    #2 rst_n = 1'b0;
    #1;
    model_clear(); m_phase = 0;
    check_all();
    chk("rst_ready", 32'(round_ready), 0);
    round_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 2'b11, 2'b10);
    step(0, 1, 2'b10, 2'b01);

    // Random play against the model.
    for (int i = 0; i < 400; i++) begin
      bit s, v;
      logic [1:0] p, c;
      s = (m_phase != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      v = $urandom_range(0, 3) != 0;
      p = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      c = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      step(s, v, p, c);
    end

    // First to 3 of at most 5: computer wins 3 of 4.
    stepb(1, 0, 2'b00, 2'b00);
    stepb(0, 1, 2'b01, 2'b10);
    stepb(0, 1, 2'b10, 2'b01);
    stepb(0, 1, 2'b11, 2'b01);
    stepb(0, 1, 2'b10, 2'b11);
    chk("b_cscore", 32'(computer_score_b), 3);
    chk("b_pscore", 32'(player_score_b), 1);
    chk("b_rounds", 32'(round_count_b), 4);
    chk("b_done", 32'(match_done_b), 1);
    chk("b_pwins", 32'(player_wins_b), 0);
    chk("b_draw", 32'(match_draw_b), 0);
    chk("b_ready", 32'(round_ready_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
